// File: rtl/out_spike_aer.sv
// Collects per-group spike words into a full spike vector and a per-timestep spike count.
// Define OUT_SPIKE_AER_EN to build the AER group FIFO and one-address-per-handshake serializer.
module out_spike_aer #(
  parameter int GROUP_W    = 16,
  parameter int N_GROUPS   = 64,
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int ACC_MODE   = 0,
  parameter int CNT_W      = 16
) (
  input  logic                              CLK,
  input  logic                              RST_sync,
  input  logic [GROUP_W-1:0]                LIF_neuron_event_out,
  input  logic                              CTRL_PIPLINE_START,
  input  logic [ADDR_W-1:0]                 CTRL_NEURMEM_ADDR,
  input  logic                              CTRL_TIMESTEP_END,
  output logic [GROUP_W*N_GROUPS-1:0]       Neuron_Out_Spike,
  output logic [CNT_W-1:0]                  Spike_Count_Last,
  output logic [ADDR_W+$clog2(GROUP_W)-1:0] AER_OUT_ADDR,
  output logic                              AER_OUT_VALID,
  input  logic                              AER_OUT_READY,
  output logic                              AER_OVERFLOW
);
  localparam int AW    = ADDR_W + $clog2(GROUP_W);
  localparam int BI_W  = $clog2(GROUP_W);
  localparam int POP_W = $clog2(GROUP_W + 1);

  logic             accept;
  logic [POP_W-1:0] pop_cnt;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_sat;
  logic [CNT_W-1:0] run_cnt;

  always_comb begin
    accept  = CTRL_PIPLINE_START && (32'(CTRL_NEURMEM_ADDR) < N_GROUPS);
    pop_cnt = accept ? POP_W'($countones(LIF_neuron_event_out)) : '0;
    // One extra carry bit detects wrap so the running total pins at all-ones.
    cnt_sum = {1'b0, run_cnt} + (CNT_W+1)'(pop_cnt);
    cnt_sat = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST_sync) begin
      Neuron_Out_Spike <= '0;
      run_cnt          <= '0;
      Spike_Count_Last <= '0;
    end else begin
      for (int g = 0; g < N_GROUPS; g++) begin
        if (ACC_MODE == 0)
          Neuron_Out_Spike[g*GROUP_W +: GROUP_W] <=
            (accept && (32'(CTRL_NEURMEM_ADDR) == g)) ? LIF_neuron_event_out : '0;
        else if (CTRL_TIMESTEP_END)
          Neuron_Out_Spike[g*GROUP_W +: GROUP_W] <= '0;
        else if (accept && (32'(CTRL_NEURMEM_ADDR) == g))
          Neuron_Out_Spike[g*GROUP_W +: GROUP_W] <=
            Neuron_Out_Spike[g*GROUP_W +: GROUP_W] | LIF_neuron_event_out;
      end
      if (CTRL_TIMESTEP_END) begin
        Spike_Count_Last <= cnt_sat;
        run_cnt          <= '0;
      end else begin
        run_cnt <= cnt_sat;
      end
    end
  end

`ifdef OUT_SPIKE_AER_EN
  localparam int             PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [ADDR_W-1:0]  fifo_g    [FIFO_DEPTH];
  logic [GROUP_W-1:0] fifo_word [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr, rd_ptr;
  logic [GROUP_W-1:0] done_mask, pending, low_bit;
  logic [BI_W-1:0]    bit_idx;
  logic               empty, full, fire, pop, push_req, push_ok;

  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = ((wr_ptr - rd_ptr) == (PTR_W+1)'(FIFO_DEPTH));
    // The head entry stays in the FIFO while serialized; done_mask records emitted bits.
    pending = fifo_word[rd_ptr[PTR_W-1:0]] & ~done_mask;
    bit_idx = '0;
    for (int b = GROUP_W - 1; b >= 0; b--)
      if (pending[b]) bit_idx = BI_W'(b);
    low_bit       = GROUP_W'(1) << bit_idx;
    AER_OUT_VALID = !empty && (pending != '0);
    AER_OUT_ADDR  = AW'(fifo_g[rd_ptr[PTR_W-1:0]]) * AW'(GROUP_W) + AW'(bit_idx);
    fire          = AER_OUT_VALID && AER_OUT_READY;
    pop           = fire && ((pending & ~low_bit) == '0);
    push_req      = accept && (LIF_neuron_event_out != '0);
    push_ok       = push_req && (!full || pop);
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers alone decide which entries are live.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      fifo_g[wr_ptr[PTR_W-1:0]]    <= CTRL_NEURMEM_ADDR;
      fifo_word[wr_ptr[PTR_W-1:0]] <= LIF_neuron_event_out;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_sync) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      done_mask    <= '0;
      AER_OVERFLOW <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      else if (push_req)
        AER_OVERFLOW <= 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        done_mask <= '0;
      end else if (fire) begin
        done_mask <= done_mask | low_bit;
      end
    end
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic unused_ready;

  assign unused_ready  = AER_OUT_READY;
  assign AER_OUT_VALID = 1'b0;
  assign AER_OUT_ADDR  = '0;
  assign AER_OVERFLOW  = 1'b0;
`endif

endmodule

// File: tb/tb_out_spike_aer.sv
// Drives a pulse-mode and an accumulate-mode instance with identical stimulus and
// compares both against a queue-based behavioural model every cycle.
module tb_out_spike_aer;
  localparam int GROUP_W    = 16;
  localparam int N_GROUPS   = 64;
  localparam int ADDR_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 16;
  localparam int N          = GROUP_W * N_GROUPS;
  localparam int AW         = ADDR_W + 4;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
`ifdef OUT_SPIKE_AER_EN
  localparam bit AER_EN = 1'b1;
`else
  localparam bit AER_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST_sync, start, ts_end, ready;
  logic [15:0]       word;
  logic [7:0]        addr;
  logic [N-1:0]      vec_p, vec_a;
  logic [CNT_W-1:0]  last_p, last_a;
  logic [AW-1:0]     aer_addr_p, aer_addr_a;
  logic              valid_p, valid_a, ovf_p, ovf_a;

  always #5 CLK = ~CLK;

  out_spike_aer #(.GROUP_W(GROUP_W), .N_GROUPS(N_GROUPS), .ADDR_W(ADDR_W),
                  .FIFO_DEPTH(FIFO_DEPTH), .ACC_MODE(0), .CNT_W(CNT_W)) u_pulse (
    .CLK(CLK), .RST_sync(RST_sync), .LIF_neuron_event_out(word),
    .CTRL_PIPLINE_START(start), .CTRL_NEURMEM_ADDR(addr), .CTRL_TIMESTEP_END(ts_end),
    .Neuron_Out_Spike(vec_p), .Spike_Count_Last(last_p), .AER_OUT_ADDR(aer_addr_p),
    .AER_OUT_VALID(valid_p), .AER_OUT_READY(ready), .AER_OVERFLOW(ovf_p));

  out_spike_aer #(.GROUP_W(GROUP_W), .N_GROUPS(N_GROUPS), .ADDR_W(ADDR_W),
                  .FIFO_DEPTH(FIFO_DEPTH), .ACC_MODE(1), .CNT_W(CNT_W)) u_acc (
    .CLK(CLK), .RST_sync(RST_sync), .LIF_neuron_event_out(word),
    .CTRL_PIPLINE_START(start), .CTRL_NEURMEM_ADDR(addr), .CTRL_TIMESTEP_END(ts_end),
    .Neuron_Out_Spike(vec_a), .Spike_Count_Last(last_a), .AER_OUT_ADDR(aer_addr_a),
    .AER_OUT_VALID(valid_a), .AER_OUT_READY(ready), .AER_OVERFLOW(ovf_a));

  // Reference model: each FIFO entry keeps the bits still waiting to be emitted.
  typedef struct {
    int          g;
    logic [15:0] rem;
  } entry_t;

  entry_t       q[$];
  logic [N-1:0] m_pulse = '0;
  logic [N-1:0] m_acc   = '0;
  int           m_run   = 0;
  int           m_last  = 0;
  bit           m_ovf   = 1'b0;
  int           total   = 0;
  int           bad     = 0;

  function automatic int lowest(logic [15:0] v);
    for (int i = 0; i < 16; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(string tag, logic [N-1:0] obs, logic [N-1:0] exp);
    int g;
    total++;
    assert (obs === exp) else begin
      bad++;
      g = 0;
      for (int i = N_GROUPS - 1; i >= 0; i--)
        if (obs[i*GROUP_W +: GROUP_W] !== exp[i*GROUP_W +: GROUP_W]) g = i;
      $error("FAIL %s group=%0d observed=%h expected=%h", tag, g,
             obs[g*GROUP_W +: GROUP_W], exp[g*GROUP_W +: GROUP_W]);
    end
  endtask

  task automatic model_step();
    bit     acc_ok;
    int     pc, sum;
    entry_t e;
    if (RST_sync) begin
      m_pulse = '0; m_acc = '0; m_run = 0; m_last = 0; m_ovf = 1'b0;
      q.delete();
      return;
    end
    acc_ok = start && (int'(addr) < N_GROUPS);
    pc     = acc_ok ? $countones(word) : 0;
    m_pulse = '0;
    if (acc_ok) m_pulse[int'(addr)*GROUP_W +: GROUP_W] = word;
    if (ts_end) m_acc = '0;
    else if (acc_ok) m_acc[int'(addr)*GROUP_W +: GROUP_W] |= word;
    sum = (m_run + pc > CNT_MAX) ? CNT_MAX : m_run + pc;
    if (ts_end) begin
      m_last = sum;
      m_run  = 0;
    end else begin
      m_run = sum;
    end
    if (ready && q.size() > 0) begin
      q[0].rem = q[0].rem & (q[0].rem - 16'd1);
      if (q[0].rem == 16'd0) void'(q.pop_front());
    end
    if (AER_EN && acc_ok && word != 16'd0) begin
      if (q.size() < FIFO_DEPTH) begin
        e.g = int'(addr);
        e.rem = word;
        q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    bit exp_valid;
    int exp_addr;
    exp_valid = (q.size() > 0);
    check_vec("pulse_vec", vec_p, m_pulse);
    check_vec("acc_vec", vec_a, m_acc);
    check("pulse_count_last", 64'(last_p), 64'(m_last));
    check("acc_count_last", 64'(last_a), 64'(m_last));
    check("pulse_valid", 64'(valid_p), 64'(exp_valid));
    check("acc_valid", 64'(valid_a), 64'(exp_valid));
    check("pulse_overflow", 64'(ovf_p), 64'(m_ovf));
    check("acc_overflow", 64'(ovf_a), 64'(m_ovf));
    if (exp_valid) begin
      exp_addr = q[0].g * GROUP_W + lowest(q[0].rem);
      check("pulse_aer_addr", 64'(aer_addr_p), 64'(exp_addr));
      check("acc_aer_addr", 64'(aer_addr_a), 64'(exp_addr));
    end
  endtask

  task automatic cyc(bit s, int a, logic [15:0] w, bit e, bit r, bit rst);
    start = s; addr = 8'(a); word = w; ts_end = e; ready = r; RST_sync = rst;
    model_step();
    @(posedge CLK);
    #1;
    check_all();
  endtask

  initial begin
    logic [15:0] w;
    int          k;
    start = 0; addr = 0; word = 0; ts_end = 0; ready = 0; RST_sync = 1;
    cyc(0, 0, 16'h0, 0, 0, 1);
    cyc(0, 0, 16'h0, 0, 0, 1);
    cyc(0, 0, 16'h0, 0, 1, 0);

    // Pulse: group 3 word 8001 -> bits 48 and 63 for one cycle.
    cyc(1, 3, 16'h8001, 0, 1, 0);
    check("bit48", 64'(vec_p[48]), 64'd1);
    check("bit63", 64'(vec_p[63]), 64'd1);
    cyc(0, 0, 16'h0, 0, 1, 0);
    cyc(0, 0, 16'h0, 1, 1, 0);

    // Accumulate: two words to group 5 held until the timestep ends.
    cyc(1, 5, 16'h0001, 0, 1, 0);
    cyc(1, 5, 16'h0100, 0, 1, 0);
    check("bit80_88", 64'({vec_a[88], vec_a[80]}), 64'd3);
    cyc(0, 0, 16'h0, 0, 1, 0);
    cyc(0, 0, 16'h0, 1, 1, 0);
    check("count_after_end", 64'(last_a), 64'd2);
    cyc(0, 0, 16'h0, 0, 1, 0);

    // AER with READY high: group 2 word 0005 -> 32 then 34.
    cyc(1, 2, 16'h0005, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0, 0, 1, 0);

    // Backpressure: FIFO_DEPTH+1 strobes stalled, hold, then drain.
    for (int i = 0; i < FIFO_DEPTH + 1; i++)
      cyc(1, (i * 7) % N_GROUPS, 16'(16'h8000 | (16'h1 << (i % 15))), 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 16'h0, 0, 0, 0);
    for (int i = 0; i < 200 && q.size() > 0; i++)
      cyc(0, 0, 16'h0, 0, ($urandom_range(0, 3) != 0), 0);
    cyc(0, 0, 16'h0, 1, 1, 0);

    // Out-of-range groups are ignored entirely.
    cyc(1, 64, 16'hFFFF, 0, 1, 0);
    cyc(1, 255, 16'hFFFF, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, $urandom_range(64, 255), 16'(16'hFFFF), 0, 1, 0);

    // Random traffic including end+strobe collisions and zero words.
    for (int i = 0; i < 800; i++) begin
      k = $urandom_range(0, 9);
      if (k < 2) w = 16'h0;
      else if (k < 6) w = 16'(16'h1 << $urandom_range(0, 15));
      else if (k < 8) w = 16'($urandom) & 16'($urandom);
      else w = 16'($urandom);
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 71), w,
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 0);
    end

    // Reset in the middle of serializing an all-ones word.
    for (int i = 0; i < 60 && q.size() > 0; i++) cyc(0, 0, 16'h0, 0, 1, 0);
    cyc(1, 7, 16'hFFFF, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0, 0, 1, 0);
    cyc(1, 9, 16'hFFFF, 1, 1, 1);
    check("reset_valid", 64'(valid_p), 64'd0);
    check("reset_overflow", 64'(ovf_p), 64'd0);
    check("reset_count", 64'(last_a), 64'd0);
    cyc(0, 0, 16'h0, 1, 1, 0);

    // Saturation: 4200 all-ones strobes exceed 2^16-1, ending with a same-cycle strobe.
    for (int i = 0; i < 4200; i++)
      cyc(1, i % N_GROUPS, 16'hFFFF, 0, ($urandom_range(0, 1) != 0), 0);
    cyc(1, 1, 16'hFFFF, 1, 1, 0);
    check("count_saturated", 64'(last_p), 64'(CNT_MAX));
    cyc(1, 4, 16'h0003, 0, 1, 0);
    cyc(0, 0, 16'h0, 1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 16'h0, 0, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/out_spike_aer.md
OUT_SPIKE_AER -- requirements
Module: out_spike_aer

Interface
REQ-001 SHALL have parameter GROUP_W, default 16: neurons per group (per strobe).
REQ-002 SHALL have parameter N_GROUPS, default 64: groups; total neurons N = GROUP_W*N_GROUPS.
REQ-003 SHALL have parameter ADDR_W, default 8: group address width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16: AER group-FIFO entries, power of two.
REQ-005 SHALL have parameter ACC_MODE, default 0: 0 = pulse mode, 1 = accumulate-per-timestep mode.
REQ-006 SHALL have parameter CNT_W, default 16: spike counter width.
REQ-007 SHALL have port CLK, input, 1: sole clock, rising edge.
REQ-008 SHALL have port RST_sync, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port LIF_neuron_event_out, input, GROUP_W: spike word of addressed group.
REQ-010 SHALL have port CTRL_PIPLINE_START, input, 1: strobe qualifying the word and address.
REQ-011 SHALL have port CTRL_NEURMEM_ADDR, input, ADDR_W: group index.
REQ-012 SHALL have port CTRL_TIMESTEP_END, input, 1: one-cycle end-of-timestep pulse.
REQ-013 SHALL have port Neuron_Out_Spike, output, N: spike vector; bit g*GROUP_W+b = neuron b of group g.
REQ-014 SHALL have port Spike_Count_Last, output, CNT_W: spike total of last completed timestep.
REQ-015 SHALL have port AER_OUT_ADDR, output, ADDR_W+clog2(GROUP_W): neuron address g*GROUP_W+b.
REQ-016 SHALL have ports AER_OUT_VALID (output, 1) and AER_OUT_READY (input, 1): AER valid/ready handshake.
REQ-017 SHALL have port AER_OVERFLOW, output, 1: sticky FIFO-drop flag.

Function
REQ-018 A strobe SHALL be accepted only when CTRL_PIPLINE_START=1 and CTRL_NEURMEM_ADDR<N_GROUPS; out-of-range strobes SHALL be ignored entirely.
REQ-019 Pulse mode: cycle after an accepted strobe, slice g SHALL equal the word and all other slices 0; without a strobe the whole vector SHALL be 0 next cycle.
REQ-020 Accumulate mode: an accepted strobe SHALL OR the word into slice g, visible next cycle; bits held until CTRL_TIMESTEP_END.
REQ-021 Accumulate mode: CTRL_TIMESTEP_END SHALL zero the whole vector next cycle; a strobe in the same cycle SHALL NOT be retained in the vector.
REQ-022 Running counter SHALL add popcount of each accepted word, saturating at 2^CNT_W-1.
REQ-023 On CTRL_TIMESTEP_END, Spike_Count_Last SHALL load running total plus same-cycle accepted popcount (saturated), valid next cycle; running counter SHALL clear.
REQ-024 An accepted strobe with nonzero word SHALL push {g, word} into the FIFO; zero words SHALL NOT be pushed.
REQ-025 Serializer SHALL emit set bits of head entry one per handshake, lowest bit first; AER_OUT_ADDR = g*GROUP_W+b.
REQ-026 AER_OUT_VALID SHALL be high whenever the head entry has a pending bit; ADDR/VALID SHALL hold stable while VALID=1 and READY=0.
REQ-027 On a handshake consuming the last set bit, head SHALL pop; next entry SHALL be presented next cycle (one bubble allowed).
REQ-028 Push when full SHALL be accepted if the head pops in the same cycle; otherwise the entry SHALL be dropped and AER_OVERFLOW set.
REQ-029 CTRL_TIMESTEP_END SHALL NOT flush the FIFO or clear AER_OVERFLOW.

Reset
REQ-030 RST_sync SHALL clear Neuron_Out_Spike, counter, Spike_Count_Last, FIFO pointers, serializer state, AER_OVERFLOW; AER_OUT_VALID=0 next cycle.
REQ-031 Reset SHALL dominate all inputs in the same cycle, including mid-serialization; a partially emitted entry SHALL be discarded.

Configuration
REQ-032 With macro OUT_SPIKE_AER_EN defined, FIFO and serializer SHALL be built per REQ-024..029.
REQ-033 Without OUT_SPIKE_AER_EN, no FIFO SHALL be built; AER_OUT_VALID, AER_OUT_ADDR, AER_OVERFLOW SHALL be constant 0 and AER_OUT_READY ignored; REQ-018..023 unchanged.

Verification
REQ-034 ACC_MODE=0: strobe addr=3, word=16'h8001 -> next cycle bits 48 and 63 set, all others 0; following cycle all 0.
REQ-035 ACC_MODE=1: words 16'h0001 then 16'h0100 to addr 5, then TIMESTEP_END -> bits 80,88 held; vector 0 and Spike_Count_Last=2 after end.
REQ-036 AER, READY=1: strobe addr=2 word=16'h0005 -> AER_OUT_ADDR 32 then 34 on consecutive handshakes, then VALID=0.
REQ-037 Backpressure: READY=0 for 5 cycles with VALID=1 -> ADDR stable; FIFO_DEPTH+1 nonzero strobes with READY=0 -> AER_OVERFLOW=1, first FIFO_DEPTH entries drain intact.
REQ-038 Out-of-range addr=64 with word 16'hFFFF -> no vector change, count unchanged, no AER output.
REQ-039 RST_sync during serialization of 16'hFFFF -> VALID=0, count 0, AER_OVERFLOW=0 next cycle.
